// File: rtl/apple_eat_tracker_pkg.sv
// Shared game definitions used by the apple stage and the eat tracker.
package apple_eat_tracker_pkg;

    localparam int GAME_MAX_LENGTH = 30;

    typedef enum logic [0:0] {
        ARMED = 1'b0,
        EATEN = 1'b1
    } apple_state_t;

    function automatic logic [7:0] pack_loc(input logic [3:0] y, input logic [3:0] x);
        return {y, x};
    endfunction

endpackage

// File: rtl/apple_eat_tracker_bcd_score_counter.sv
// Two-digit BCD score counter that saturates at 99.
module bcd_score_counter (
    input  logic       system_clk,
    input  logic       reset,
    input  logic       inc,
    output logic [3:0] score_tens,
    output logic [3:0] score_ones
);

    logic [3:0] tens_r;
    logic [3:0] ones_r;

    // BCD increment with carry, holding once 99 is reached
    always_ff @(posedge system_clk or posedge reset) begin
        if (reset) begin
            tens_r <= 4'd0;
            ones_r <= 4'd0;
        end else if (inc && !(tens_r == 4'd9 && ones_r == 4'd9)) begin
            if (ones_r == 4'd9) begin
                ones_r <= 4'd0;
                tens_r <= tens_r + 4'd1;
            end else begin
                ones_r <= ones_r + 4'd1;
            end
        end
    end

    assign score_tens = tens_r;
    assign score_ones = ones_r;

endmodule

// File: rtl/apple_eat_tracker.sv
// Detects head/apple collisions, emits one-shot eat pulses, tracks length and score.
module apple_eat_tracker
    import apple_eat_tracker_pkg::*;
#(
    parameter int MAX_LENGTH  = apple_eat_tracker_pkg::GAME_MAX_LENGTH,
    parameter int INIT_LENGTH = 3,
    parameter int LW          = $clog2(MAX_LENGTH + 1)
) (
    input  logic          system_clk,
    input  logic          reset,
    input  logic          clk_body,
    input  logic          enable_in,
    input  logic [3:0]    snake_head_x,
    input  logic [3:0]    snake_head_y,
    input  logic [7:0]    apple_location1,
    input  logic [7:0]    apple_location2,
    output logic          good_collision,
    output logic          good_collision2,
    output logic          grow,
    output logic [LW-1:0] snake_length,
    output logic [3:0]    score_tens,
    output logic [3:0]    score_ones,
    output logic          max_reached
);

    logic [7:0]    head_key_s;
    logic [7:0]    loc_s [2];
    logic [1:0]    hit_s;
    logic [1:0]    gate_s;
    logic [1:0]    eat_s;
    logic          eat_any_s;
    logic          good_collision_r;
    logic          good_collision2_r;
    logic          grow_r;
    logic          grow_nx_s;
    logic [LW-1:0] length_r;
    logic [LW-1:0] length_nx_s;
    logic          max_reached_r;

    assign head_key_s = pack_loc(snake_head_y, snake_head_x);
    assign loc_s[0]   = apple_location1;
    assign loc_s[1]   = apple_location2;
    assign gate_s     = {enable_in, 1'b1};
    // Apple 2 only counts when it sits on a different cell than apple 1
    assign hit_s[0]   = (head_key_s == apple_location1);
    assign hit_s[1]   = enable_in && (head_key_s == apple_location2)
                        && (apple_location2 != apple_location1);

    for (genvar i = 0; i < 2; i++) begin : g_apple
        apple_state_t state_r;
        apple_state_t state_nx_s;
        logic [7:0]   eaten_loc_r;
        logic [7:0]   eaten_loc_nx_s;
        logic         eat_nx_s;

        // Per-apple state and remembered eaten location
        always_ff @(posedge system_clk or posedge reset) begin
            if (reset) begin
                state_r     <= ARMED;
                eaten_loc_r <= 8'h00;
            end else begin
                state_r     <= state_nx_s;
                eaten_loc_r <= eaten_loc_nx_s;
            end
        end

        // Armed/eaten transitions; the apple re-arms once its location moves
        always_comb begin
            state_nx_s     = state_r;
            eaten_loc_nx_s = eaten_loc_r;
            eat_nx_s       = 1'b0;
            if (!gate_s[i]) begin
                state_nx_s = ARMED;
            end else begin
                case (state_r)
                    ARMED: begin
                        if (clk_body && hit_s[i]) begin
                            state_nx_s     = EATEN;
                            eaten_loc_nx_s = loc_s[i];
                            eat_nx_s       = 1'b1;
                        end else begin
                            state_nx_s = ARMED;
                        end
                    end
                    EATEN: begin
                        if (loc_s[i] != eaten_loc_r) begin
                            state_nx_s = ARMED;
                        end else begin
                            state_nx_s = EATEN;
                        end
                    end
                    default: begin
                        state_nx_s = ARMED;
                    end
                endcase
            end
        end

        assign eat_s[i] = eat_nx_s;
    end

    assign eat_any_s = |eat_s;

    // Length grows on each eat until the cap
    always_comb begin
        length_nx_s = length_r;
        grow_nx_s   = 1'b0;
        if (eat_any_s && (length_r < LW'(MAX_LENGTH))) begin
            length_nx_s = length_r + LW'(1);
            grow_nx_s   = 1'b1;
        end else begin
            length_nx_s = length_r;
            grow_nx_s   = 1'b0;
        end
    end

    // Registered pulses, length and cap flag
    always_ff @(posedge system_clk or posedge reset) begin
        if (reset) begin
            good_collision_r  <= 1'b0;
            good_collision2_r <= 1'b0;
            grow_r            <= 1'b0;
            length_r          <= LW'(INIT_LENGTH);
            max_reached_r     <= (INIT_LENGTH == MAX_LENGTH);
        end else begin
            good_collision_r  <= eat_s[0];
            good_collision2_r <= eat_s[1];
            grow_r            <= grow_nx_s;
            length_r          <= length_nx_s;
            max_reached_r     <= (length_nx_s == LW'(MAX_LENGTH));
        end
    end

    bcd_score_counter u_score (
        .system_clk (system_clk),
        .reset      (reset),
        .inc        (eat_any_s),
        .score_tens (score_tens),
        .score_ones (score_ones)
    );

    assign good_collision  = good_collision_r;
    assign good_collision2 = good_collision2_r;
    assign grow            = grow_r;
    assign snake_length    = length_r;
    assign max_reached     = max_reached_r;

endmodule

// File: tb/tb_apple_eat_tracker.sv
// Directed bench for apple_eat_tracker with a cycle-level behavioural model.
module tb_apple_eat_tracker;

    logic       system_clk = 1'b0;
    logic       reset = 1'b0;
    logic       clk_body = 1'b0;
    logic       enable_in = 1'b0;
    logic [3:0] snake_head_x = 4'd0;
    logic [3:0] snake_head_y = 4'd0;
    logic [7:0] apple_location1 = 8'hF0;
    logic [7:0] apple_location2 = 8'hF1;
    logic       good_collision;
    logic       good_collision2;
    logic       grow;
    logic [4:0] snake_length;
    logic [3:0] score_tens;
    logic [3:0] score_ones;
    logic       max_reached;

    int n_pass = 0;
    int n_total = 0;
    int eats = 0;

    // behavioural model state
    bit        m_eaten [2];
    bit [7:0]  m_loc [2];
    int        m_score;
    int        m_len;
    bit        m_p1, m_p2, m_grow;

    apple_eat_tracker dut (
        .system_clk      (system_clk),
        .reset           (reset),
        .clk_body        (clk_body),
        .enable_in       (enable_in),
        .snake_head_x    (snake_head_x),
        .snake_head_y    (snake_head_y),
        .apple_location1 (apple_location1),
        .apple_location2 (apple_location2),
        .good_collision  (good_collision),
        .good_collision2 (good_collision2),
        .grow            (grow),
        .snake_length    (snake_length),
        .score_tens      (score_tens),
        .score_ones      (score_ones),
        .max_reached     (max_reached)
    );

    always #5 system_clk = ~system_clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_reset();
        m_eaten[0] = 1'b0; m_eaten[1] = 1'b0;
        m_loc[0] = 8'h00;  m_loc[1] = 8'h00;
        m_score = 0; m_len = 3;
        m_p1 = 1'b0; m_p2 = 1'b0; m_grow = 1'b0;
    endtask

    // Predict what the next edge must produce from the current inputs.
    task automatic model_step();
        bit [7:0] key;
        bit h1, h2;
        key = {snake_head_y, snake_head_x};
        h1 = (key == apple_location1);
        h2 = enable_in && (key == apple_location2) && (apple_location2 != apple_location1);
        m_p1 = clk_body && h1 && !m_eaten[0];
        m_p2 = clk_body && h2 && !m_eaten[1];
        if (m_p1) begin m_eaten[0] = 1'b1; m_loc[0] = apple_location1; end
        else if (m_eaten[0] && apple_location1 != m_loc[0]) m_eaten[0] = 1'b0;
        if (!enable_in) m_eaten[1] = 1'b0;
        else if (m_p2) begin m_eaten[1] = 1'b1; m_loc[1] = apple_location2; end
        else if (m_eaten[1] && apple_location2 != m_loc[1]) m_eaten[1] = 1'b0;
        m_grow = 1'b0;
        if (m_p1 || m_p2) begin
            if (m_score < 99) m_score++;
            if (m_len < 30) begin m_len++; m_grow = 1'b1; end
        end
    endtask

    task automatic compare_all();
        chk("good_collision", int'(good_collision), int'(m_p1));
        chk("good_collision2", int'(good_collision2), int'(m_p2));
        chk("grow", int'(grow), int'(m_grow));
        chk("snake_length", int'(snake_length), m_len);
        chk("score_tens", int'(score_tens), m_score / 10);
        chk("score_ones", int'(score_ones), m_score % 10);
        chk("max_reached", int'(max_reached), int'(m_len == 30));
    endtask

    // One clock: model predicts, edge occurs, outputs are compared, return at negedge.
    task automatic tick();
        model_step();
        @(posedge system_clk);
        #1;
        compare_all();
        @(negedge system_clk);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        chk("reset_length_lit", int'(snake_length), 3);
        chk("reset_score_lit", int'(score_tens) * 10 + int'(score_ones), 0);
        chk("reset_max_lit", int'(max_reached), 0);
        @(negedge system_clk);
        reset = 1'b0;
    endtask

    task automatic set_head(input bit [7:0] key);
        snake_head_y = key[7:4];
        snake_head_x = key[3:0];
    endtask

    // Move apple 1 to a new cell, let it re-arm, then strobe onto it.
    task automatic eat_at(input bit [7:0] key);
        clk_body = 1'b0;
        apple_location1 = key;
        tick();
        set_head(key);
        clk_body = 1'b1;
        tick();
        clk_body = 1'b0;
        eats++;
    endtask

    initial begin
        model_reset();
        @(negedge system_clk);
        do_reset();
        tick();

        // single eat at 0x34
        apple_location1 = 8'h34;
        snake_head_x = 4'd4; snake_head_y = 4'd3;
        clk_body = 1'b1;
        tick();
        eats++;
        chk("eat1_pulse_lit", int'(good_collision), 1);
        chk("eat1_grow_lit", int'(grow), 1);
        chk("eat1_len_lit", int'(snake_length), 4);
        chk("eat1_score_lit", int'(score_ones), 1);
        clk_body = 1'b0;
        tick();
        chk("eat1_one_shot_lit", int'(good_collision), 0);
        clk_body = 1'b1;
        tick();
        chk("eaten_no_repeat_lit", int'(good_collision), 0);

        // location change with strobe in the same cycle still sees EATEN
        apple_location1 = 8'h78;
        snake_head_x = 4'd8; snake_head_y = 4'd7;
        tick();
        chk("rearm_same_cycle_lit", int'(good_collision), 0);
        tick();
        eats++;
        chk("rearm_pulse_lit", int'(good_collision), 1);
        chk("rearm_score_lit", int'(score_ones), 2);
        chk("rearm_len_lit", int'(snake_length), 5);
        clk_body = 1'b0;
        tick();

        // two-apple gating
        enable_in = 1'b0;
        apple_location2 = 8'h21;
        snake_head_x = 4'd1; snake_head_y = 4'd2;
        clk_body = 1'b1;
        tick();
        chk("gated_no_pulse_lit", int'(good_collision2), 0);
        enable_in = 1'b1;
        tick();
        eats++;
        chk("apple2_pulse_lit", int'(good_collision2), 1);
        chk("apple2_score_lit", int'(score_ones), 3);
        clk_body = 1'b0;
        tick();

        // coincident apples
        apple_location1 = 8'h55;
        apple_location2 = 8'h55;
        tick();
        snake_head_x = 4'd5; snake_head_y = 4'd5;
        clk_body = 1'b1;
        tick();
        eats++;
        chk("coinc_p1_lit", int'(good_collision), 1);
        chk("coinc_p2_lit", int'(good_collision2), 0);
        chk("coinc_score_lit", int'(score_ones), 4);
        clk_body = 1'b0;
        tick();

        // saturation of length then score
        while (eats < 27) eat_at((eats % 2) ? 8'h11 : 8'h22);
        tick();
        chk("len_cap_lit", int'(snake_length), 30);
        chk("max_reached_lit", int'(max_reached), 1);
        eat_at((eats % 2) ? 8'h11 : 8'h22);
        chk("capped_pulse_lit", int'(good_collision), 1);
        chk("capped_grow_lit", int'(grow), 0);
        chk("capped_len_lit", int'(snake_length), 30);
        while (eats < 99) eat_at((eats % 2) ? 8'h11 : 8'h22);
        chk("score99_lit", int'(score_tens) * 10 + int'(score_ones), 99);
        eat_at((eats % 2) ? 8'h11 : 8'h22);
        chk("eat100_pulse_lit", int'(good_collision), 1);
        chk("score_sat_lit", int'(score_tens) * 10 + int'(score_ones), 99);

        // mid-run reset with an eat about to land
        apple_location1 = 8'h9A;
        tick();
        set_head(8'h9A);
        clk_body = 1'b1;
        do_reset();
        clk_body = 1'b0;
        tick();
        chk("post_reset_len_lit", int'(snake_length), 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
